mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Sequences and shares the single-port unified memory of the multicycle core between two requesters:
//  the CPU (controller-driven iord/memwrite accesses) and a DMA/program loader.
//  One transaction at a time; round-robin on contention; fixed-latency memory tracked by a wait counter.
//  The requester stalls until its one-cycle ready pulse (CPU folds !cpu_ready into its state hold / pcen).
// PARAMETERS
//  DATA_W   16  data width of memory and both requesters
//  ADDR_W   16  address width
//  MEM_LAT  2   cycles from the mem_en cycle to the cycle mem_rdata is valid; legal 1..15
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-low (reset==0 clears all state at the edge)
//  cpu_req    in   1       CPU access request; held high until cpu_ready
//  cpu_we     in   1       1=write, 0=read; sampled at grant
//  cpu_addr   in   ADDR_W  sampled at grant
//  cpu_wdata  in   DATA_W  sampled at grant
//  cpu_ready  out  1       one-cycle pulse: CPU transaction complete
//  cpu_rdata  out  DATA_W  read data, valid with cpu_ready, held until next CPU read completes
//  dma_req/dma_we/dma_addr/dma_wdata/dma_ready/dma_rdata  same roles/widths for DMA
//  mem_en     out  1       memory strobe, exactly one cycle per transaction
//  mem_we     out  1       write strobe, only ever high together with mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1       high in every state except IDLE
//  owner      out  1       0=CPU, 1=DMA; current/last granted requester
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (ready pulses, rdata regs, mem_*, busy, owner); last_grant=DMA,
//   so the CPU wins the first tie. Reset mid-transaction aborts it: no ready pulse; mem_en/mem_we are 0 from the next edge.
//  FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  - IDLE: if no req, stay. If only one requester has req=1, grant it.
//    If both have req=1, grant the one that is not last_grant.
//    At the grant edge: latch we/addr/wdata of the winner, set owner and last_grant, go to ISSUE.
//  - ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
//    Load cnt=MEM_LAT-1; go to WAIT.
//  - WAIT: mem_en=0, mem_we=0; mem_addr/mem_wdata hold. Each cycle: if cnt==0, then capture mem_rdata
//    into the owner's rdata register (reads only; writes leave rdata unchanged) and go to DONE; else cnt--.
//  - DONE (1 cycle): owner's ready=1, other ready=0; go to IDLE.
//  Timing: the grant edge ends cycle 0, so ISSUE=cycle 1, mem_rdata sampled in cycle 1+MEM_LAT,
//   ready in cycle 2+MEM_LAT.
//   Total latency from req seen in IDLE to ready = MEM_LAT+2 cycles. No grant in DONE: at least one IDLE cycle between transactions.
//  - req dropped after grant: the transaction still completes and ready still pulses. New req values are ignored while busy.
//  - Requester inputs changing after grant: no effect (latched copies used).
//  - Pulses: cpu_ready and dma_ready never high together; each is high only in DONE.
//  - MEM_LAT=1: cnt loads 0, WAIT lasts exactly one cycle.
//  - cnt width is 4 bits; MEM_LAT outside 1..15 is a configuration error.
// TESTING
//  1 MEM_LAT=2, CPU read addr 0x0010, mem holds 0xBEEF -> one mem_en at cycle 1 with we=0;
//    cpu_ready pulse at cycle 4 with cpu_rdata=0xBEEF.
//  2 cpu_req and dma_req both held high after reset -> grants CPU, DMA, CPU, DMA;
//    ready pulses alternate, one idle cycle between transactions.
//  3 DMA write 0x1234 to 0x0042, then CPU read 0x0042 -> mem_en&mem_we for one cycle;
//    dma_ready pulse; CPU then reads 0x1234; dma_rdata unchanged by the write.
//  4 reset=0 asserted while in WAIT -> next cycle: busy=0, mem_en=0, no ready pulse, owner=0;
//    after release a tie goes to the CPU.
//  5 MEM_LAT=1 build, single CPU read -> cpu_ready exactly 3 cycles after the request.
//  6 CPU req deasserted one cycle after grant, addr changed to 0xFFFF -> mem_addr stays the original value;
//    cpu_ready still pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ready, cpu_rdata, dma_ready, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ready, cpu_rdata, dma_ready, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the CPU and a DMA loader:
// one transaction at a time, round-robin on contention, one-cycle ready pulse on completion.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              gnt_cpu, gnt_dma, capture;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    gnt_cpu       = 1'b0;
    gnt_dma       = 1'b0;
    capture       = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.dma_ready = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (bus.cpu_req && (!bus.dma_req || last_grant)) gnt_cpu = 1'b1;
        else if (bus.dma_req)                            gnt_dma = 1'b1;
        if (gnt_cpu || gnt_dma) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_q;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.cpu_ready = !owner_q;
        bus.dma_ready = owner_q;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= 4'd0;
      last_grant  <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (gnt_cpu) begin
        we_q       <= bus.cpu_we;
        addr_q     <= bus.cpu_addr;
        wdata_q    <= bus.cpu_wdata;
        owner_q    <= 1'b0;
        last_grant <= 1'b0;
      end else if (gnt_dma) begin
        we_q       <= bus.dma_we;
        addr_q     <= bus.dma_addr;
        wdata_q    <= bus.dma_wdata;
        owner_q    <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == S_ISSUE)                  cnt <= 4'(MEM_LAT - 1);
      else if (state == S_WAIT && cnt != 0)  cnt <= cnt - 4'd1;
      // Writes complete without touching the requester's read-data register.
      if (capture && !we_q) begin
        if (owner_q) dma_rdata_q <= bus.mem_rdata;
        else         cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=2 instance exercised by directed and random
// transactions against a transaction-level model, plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) b0 ();
  mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int total = 0;
  int bad = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a * 16'h0F1D) ^ 16'hA5C3;
  endfunction

  // Memory models: read data appears exactly MEM_LAT cycles after the mem_en cycle, garbage otherwise.
  logic [15:0] mem0 [0:65535];
  bit          wr0  [0:65535];
  logic [15:0] pv0 = 16'h0;
  int          pc0 = 0;
  always @(posedge clk) begin
    if (b0.mem_en) begin
      if (b0.mem_we) begin
        mem0[b0.mem_addr] <= b0.mem_wdata;
        wr0[b0.mem_addr]  <= 1'b1;
      end
      pv0 <= wr0[b0.mem_addr] ? mem0[b0.mem_addr] : init_val(b0.mem_addr);
      pc0 <= LAT0;
    end else if (pc0 != 0) pc0 <= pc0 - 1;
  end
  assign b0.mem_rdata = (pc0 == 1) ? pv0 : 16'h0BAD;

  logic [15:0] mem1 [0:65535];
  bit          wr1  [0:65535];
  logic [15:0] pv1 = 16'h0;
  int          pc1 = 0;
  always @(posedge clk) begin
    if (b1.mem_en) begin
      if (b1.mem_we) begin
        mem1[b1.mem_addr] <= b1.mem_wdata;
        wr1[b1.mem_addr]  <= 1'b1;
      end
      pv1 <= wr1[b1.mem_addr] ? mem1[b1.mem_addr] : init_val(b1.mem_addr);
      pc1 <= LAT1;
    end else if (pc1 != 0) pc1 <= pc1 - 1;
  end
  assign b1.mem_rdata = (pc1 == 1) ? pv1 : 16'h0BAD;

  int both_rdy = 0;
  int we_noen  = 0;
  always @(posedge clk) begin
    if (b0.cpu_ready && b0.dma_ready) both_rdy <= both_rdy + 1;
    if (b0.mem_we && !b0.mem_en)      we_noen  <= we_noen + 1;
  end

  // Transaction-level reference state.
  logic [15:0] ref_mem [logic [15:0]];
  bit          m_last;
  logic [15:0] m_cpu_rd, m_dma_rd;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    b0.cpu_req = 1'b0;
    b0.dma_req = 1'b0;
    @(posedge clk); #1;
    chk1 ("rst_busy",  b0.busy,      1'b0);
    chk1 ("rst_en",    b0.mem_en,    1'b0);
    chk1 ("rst_we",    b0.mem_we,    1'b0);
    chk1 ("rst_owner", b0.owner,     1'b0);
    chk1 ("rst_crdy",  b0.cpu_ready, 1'b0);
    chk1 ("rst_drdy",  b0.dma_ready, 1'b0);
    chk16("rst_crd",   b0.cpu_rdata, 16'h0);
    chk16("rst_drd",   b0.dma_rdata, 16'h0);
    chk16("rst_addr",  b0.mem_addr,  16'h0);
    chk16("rst_wdata", b0.mem_wdata, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    m_last   = 1'b1;
    m_cpu_rd = 16'h0;
    m_dma_rd = 16'h0;
  endtask

  // Runs one transaction on dut0, starting in an idle cycle; scr changes inputs and drops req after grant.
  task automatic txn(input bit rc, input bit rd,
                     input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
                     input logic dwe, input logic [15:0] daddr, input logic [15:0] dwd,
                     input bit scr, input string tag);
    bit          win;
    logic        ewe;
    logic [15:0] ea, ewd;
    win = (rc && rd) ? !m_last : rd;
    ewe = win ? dwe : cwe;
    ea  = win ? daddr : caddr;
    ewd = win ? dwd : cwd;
    if (ewe) ref_mem[ea] = ewd;
    else if (win) m_dma_rd = ref_rd(ea);
    else m_cpu_rd = ref_rd(ea);
    m_last = win;
    b0.cpu_req = rc; b0.cpu_we = cwe; b0.cpu_addr = caddr; b0.cpu_wdata = cwd;
    b0.dma_req = rd; b0.dma_we = dwe; b0.dma_addr = daddr; b0.dma_wdata = dwd;
    chk1({tag, "_idle"}, b0.busy, 1'b0);
    for (int k = 1; k <= LAT0 + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scr) begin
        b0.cpu_req = 1'b0; b0.cpu_addr = 16'hFFFF; b0.cpu_we = !cwe; b0.cpu_wdata = 16'($urandom);
        b0.dma_req = 1'b0; b0.dma_addr = 16'hFFFF; b0.dma_we = !dwe; b0.dma_wdata = 16'($urandom);
      end
      chk1 ({tag, "_en"},    b0.mem_en,    k == 1);
      chk1 ({tag, "_we"},    b0.mem_we,    (k == 1) && ewe);
      chk16({tag, "_addr"},  b0.mem_addr,  ea);
      chk1 ({tag, "_busy"},  b0.busy,      1'b1);
      chk1 ({tag, "_owner"}, b0.owner,     win);
      chk1 ({tag, "_crdy"},  b0.cpu_ready, (k == LAT0 + 2) && !win);
      chk1 ({tag, "_drdy"},  b0.dma_ready, (k == LAT0 + 2) && win);
      if (k == 1 && ewe) chk16({tag, "_wdata"}, b0.mem_wdata, ewd);
    end
    chk16({tag, "_crd"}, b0.cpu_rdata, m_cpu_rd);
    chk16({tag, "_drd"}, b0.dma_rdata, m_dma_rd);
    b0.cpu_req = 1'b0;
    b0.dma_req = 1'b0;
    @(posedge clk); #1;
    chk1({tag, "_after_busy"}, b0.busy,      1'b0);
    chk1({tag, "_after_crdy"}, b0.cpu_ready, 1'b0);
  endtask

  int n, ph;
  bit rc, rd;

  initial begin
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
    b0.dma_req = 0; b0.dma_we = 0; b0.dma_addr = 0; b0.dma_wdata = 0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0;

    // Reset state, then a single CPU read of the 0xBEEF location.
    do_reset();
    chk1("rst1_busy", b1.busy, 1'b0);
    txn(1, 0, 0, 16'h0010, 16'h0, 0, 16'h0, 16'h0, 0, "cpu_rd");
    chk16("cpu_rd_beef", b0.cpu_rdata, 16'hBEEF);

    // Both requesters held high from reset: CPU, DMA, CPU, DMA with an idle cycle between.
    do_reset();
    b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 16'h0005;
    b0.dma_req = 1; b0.dma_we = 0; b0.dma_addr = 16'h0006;
    for (int k = 1; k <= 4 * (LAT0 + 3) - 1; k++) begin
      @(posedge clk); #1;
      n  = k / (LAT0 + 3);
      ph = k % (LAT0 + 3);
      chk1("rr_en",   b0.mem_en,    ph == 1);
      chk1("rr_crdy", b0.cpu_ready, (ph == LAT0 + 2) && (n % 2 == 0));
      chk1("rr_drdy", b0.dma_ready, (ph == LAT0 + 2) && (n % 2 == 1));
      if (ph == LAT0 + 2 && n % 2 == 0) chk16("rr_crd", b0.cpu_rdata, ref_rd(16'h0005));
      if (ph == LAT0 + 2 && n % 2 == 1) chk16("rr_drd", b0.dma_rdata, ref_rd(16'h0006));
    end
    b0.cpu_req = 0;
    b0.dma_req = 0;
    @(posedge clk); #1;
    m_last   = 1'b1;
    m_cpu_rd = ref_rd(16'h0005);
    m_dma_rd = ref_rd(16'h0006);

    // DMA write followed by CPU read-back of the same word.
    txn(0, 1, 0, 16'h0, 16'h0, 1, 16'h0042, 16'h1234, 0, "dma_wr");
    txn(1, 0, 0, 16'h0042, 16'h0, 0, 16'h0, 16'h0, 0, "cpu_rb");
    chk16("cpu_rb_1234", b0.cpu_rdata, 16'h1234);

    // Inputs changed and req dropped right after grant.
    txn(1, 0, 0, 16'h0020, 16'h0, 0, 16'h0, 16'h0, 1, "late_chg");

    for (int i = 0; i < 30; i++) begin
      rc = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!rc && !rd) rc = 1'b1;
      txn(rc, rd,
          1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
          1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
          ($urandom_range(0, 3) == 0), "rnd");
    end

    // Reset while a DMA read is waiting on memory.
    b0.dma_req = 1; b0.dma_we = 0; b0.dma_addr = 16'h0030;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("abort_owner_pre", b0.owner, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk1 ("abort_busy",  b0.busy,      1'b0);
    chk1 ("abort_en",    b0.mem_en,    1'b0);
    chk1 ("abort_we",    b0.mem_we,    1'b0);
    chk1 ("abort_owner", b0.owner,     1'b0);
    chk16("abort_crd",   b0.cpu_rdata, 16'h0);
    chk16("abort_drd",   b0.dma_rdata, 16'h0);
    reset = 1'b1;
    b0.dma_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk1("abort_no_drdy", b0.dma_ready, 1'b0);
      chk1("abort_no_crdy", b0.cpu_ready, 1'b0);
      chk1("abort_idle",    b0.busy,      1'b0);
    end
    m_last   = 1'b1;
    m_cpu_rd = 16'h0;
    m_dma_rd = 16'h0;
    txn(1, 1, 0, 16'h0007, 16'h0, 0, 16'h0008, 16'h0, 0, "post_rst_tie");
    chk1("post_rst_cpu_first", b0.owner, 1'b0);

    // MEM_LAT=1 instance: single CPU read completes three cycles after the request.
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0010;
    for (int k = 1; k <= LAT1 + 2; k++) begin
      @(posedge clk); #1;
      chk1("lat1_en",   b1.mem_en,    k == 1);
      chk1("lat1_busy", b1.busy,      1'b1);
      chk1("lat1_crdy", b1.cpu_ready, k == LAT1 + 2);
    end
    chk16("lat1_crd", b1.cpu_rdata, 16'hBEEF);
    b1.cpu_req = 0;
    @(posedge clk); #1;
    chk1("lat1_after", b1.cpu_ready, 1'b0);

    chk16("never_both_ready", 16'(both_rdy), 16'h0);
    chk16("we_without_en",    16'(we_noen),  16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
